// File: rtl/sii_cdc_hs_tx.sv
// Source-domain end of a 4-phase req/ack handshake carrying one word into another clock domain.
// ack_i is resynchronized through SYNC_STAGES flops (must be 2 or more); at most one word is in flight.
module sii_cdc_hs_tx #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic                  req_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  ack_i,
   output logic                  busy,
   output logic                  proto_err
);

   // state | meaning
   // IDLE  | waiting for a word; refuses one while the synchronized ack is still high
   // REQ   | req_o high, data_o held, waiting for the synchronized ack to rise
   // REL   | req_o low, waiting for the synchronized ack to fall
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
      end
   end

   assign ack_s     = ack_sync[SYNC_STAGES-1];
   assign src_ready = (state == IDLE) && !ack_s;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_o     <= 1'b0;
         data_o    <= '0;
         proto_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A stray ack while idle is flagged; src_ready stays low until it clears.
               if (ack_s) begin
                  proto_err <= 1'b1;
               end else if (src_valid) begin
                  data_o <= src_data;
                  req_o  <= 1'b1;
                  state  <= REQ;
               end
            end
            REQ: begin
               if (ack_s) begin
                  req_o <= 1'b0;
                  state <= REL;
               end
            end
            REL: begin
               if (!ack_s) begin
                  state <= IDLE;
               end
            end
            default: begin
               req_o <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sii_cdc_hs_tx.sv
// Bench for sii_cdc_hs_tx: a per-cycle vector table plus directed multi-cycle sequences.
// Inputs change on the falling edge and outputs are sampled 1 time unit later.
module tb_sii_cdc_hs_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        src_valid;
   logic [31:0] src_data;
   logic        src_ready;
   logic        req_o;
   logic [31:0] data_o;
   logic        ack_i;
   logic        busy;
   logic        proto_err;

   int n_checks = 0;
   int n_pass   = 0;

   sii_cdc_hs_tx #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_ready (src_ready),
      .req_o     (req_o),
      .data_o    (data_o),
      .ack_i     (ack_i),
      .busy      (busy),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] data;
      logic        ack;
      logic        e_ready;
      logic        e_req;
      logic        e_busy;
      logic        e_perr;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
      n_checks++;
      if (act >= lo && act <= hi) n_pass++;
      else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      src_valid = 1'b0;
      src_data  = '0;
      ack_i     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst req_o", req_o, 0);
      chk("rst data_o", data_o, 0);
      chk("rst busy", busy, 0);
      chk("rst proto_err", proto_err, 0);
      chk("rst src_ready", src_ready, 1);
   endtask

   // Remote end: waits for req_o, acks dly cycles later, releases once req_o drops.
   // Delays are cycles from the first sampling edge; -1 means the bound ran out.
   task automatic remote_xfer(input int dly, input logic [31:0] exp_d,
                              output int fall_dly, output int rdy_dly, output int bad);
      int n;
      bad = 0; fall_dly = -1; rdy_dly = -1; n = 0;
      while (req_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (req_o !== 1'b1) return;
      repeat (dly) begin @(negedge clk); if (data_o !== exp_d) bad++; end
      ack_i = 1'b1; n = 0;
      do begin @(negedge clk); n++; if (data_o !== exp_d) bad++; end
      while (req_o !== 1'b0 && n < 20);
      if (req_o === 1'b0) fall_dly = n - 1;
      ack_i = 1'b0; n = 0;
      do begin @(negedge clk); n++; if (data_o !== exp_d) bad++; end
      while (src_ready !== 1'b1 && n < 20);
      if (src_ready === 1'b1) rdy_dly = n - 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int fall_d, rdy_d, bad;
      int pulses, mon_bad, bad_req, bad_rdy, bad_dat;
      logic [31:0] held;
      logic req_prev;

      //             valid data          ack  rdy req busy perr data_o
      vecs[0]  = '{1'b0, 32'h0,         1'b0, 1, 0, 0, 0, 32'h0};
      vecs[1]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1, 0, 0, 0, 32'h0};
      vecs[2]  = '{1'b0, 32'h0,         1'b0, 0, 1, 1, 0, 32'hDEAD_BEEF};
      vecs[3]  = '{1'b0, 32'h0,         1'b1, 0, 1, 1, 0, 32'hDEAD_BEEF};
      vecs[4]  = '{1'b0, 32'h0,         1'b1, 0, 1, 1, 0, 32'hDEAD_BEEF};
      vecs[5]  = '{1'b0, 32'h0,         1'b1, 0, 1, 1, 0, 32'hDEAD_BEEF};
      vecs[6]  = '{1'b0, 32'h0,         1'b0, 0, 0, 1, 0, 32'hDEAD_BEEF};
      vecs[7]  = '{1'b0, 32'h0,         1'b0, 0, 0, 1, 0, 32'hDEAD_BEEF};
      vecs[8]  = '{1'b0, 32'h0,         1'b0, 0, 0, 1, 0, 32'hDEAD_BEEF};
      vecs[9]  = '{1'b0, 32'h0,         1'b1, 1, 0, 0, 0, 32'hDEAD_BEEF};
      vecs[10] = '{1'b0, 32'h0,         1'b1, 1, 0, 0, 0, 32'hDEAD_BEEF};
      vecs[11] = '{1'b1, 32'h5555_5555, 1'b1, 0, 0, 0, 0, 32'hDEAD_BEEF};
      vecs[12] = '{1'b1, 32'h5555_5555, 1'b1, 0, 0, 0, 1, 32'hDEAD_BEEF};
      vecs[13] = '{1'b1, 32'h5555_5555, 1'b0, 0, 0, 0, 1, 32'hDEAD_BEEF};
      vecs[14] = '{1'b1, 32'h5555_5555, 1'b0, 0, 0, 0, 1, 32'hDEAD_BEEF};
      vecs[15] = '{1'b1, 32'h5555_5555, 1'b0, 1, 0, 0, 1, 32'hDEAD_BEEF};
      vecs[16] = '{1'b0, 32'h0,         1'b0, 0, 1, 1, 1, 32'h5555_5555};

      do_reset();

      // Per-cycle table: one transfer, a 4-cycle stray ack in IDLE, then a transfer that still works.
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         src_valid = vecs[i].valid;
         src_data  = vecs[i].data;
         ack_i     = vecs[i].ack;
         #1;
         chk($sformatf("vec%0d src_ready", i), src_ready, vecs[i].e_ready);
         chk($sformatf("vec%0d req_o", i), req_o, vecs[i].e_req);
         chk($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
         chk($sformatf("vec%0d proto_err", i), proto_err, vecs[i].e_perr);
         chk($sformatf("vec%0d data_o", i), data_o, vecs[i].e_data);
      end

      // Single transfer against a remote that acks 3 cycles after seeing req.
      do_reset();
      @(negedge clk);
      src_valid = 1'b1; src_data = 32'hDEAD_BEEF;
      #1;
      chk("single req before accept", req_o, 0);
      @(negedge clk);
      src_valid = 1'b0; src_data = 32'h0;
      #1;
      chk("single req after accept", req_o, 1);
      chk("single data after accept", data_o, 32'hDEAD_BEEF);
      remote_xfer(3, 32'hDEAD_BEEF, fall_d, rdy_d, bad);
      chk_rng("single req fall delay", fall_d, 1, 3);
      chk_rng("single ready return delay", rdy_d, 1, 3);
      chk("single data stable", bad, 0);

      // Back-to-back: valid held high with 1, 2, 3.
      @(negedge clk);
      pulses = 0; mon_bad = 0; req_prev = 1'b0; held = '0;
      fork
         begin
            src_valid = 1'b1; src_data = 32'd1;
            for (int k = 1; k <= 3; k++) begin
               remote_xfer(2, k, fall_d, rdy_d, bad);
               chk_rng($sformatf("b2b%0d req fall delay", k), fall_d, 1, 3);
               chk($sformatf("b2b%0d data stable", k), bad, 0);
               if (k < 3) begin
                  src_data = k + 1;
                  @(negedge clk);
                  #1;
                  chk($sformatf("b2b%0d next accept", k), req_o, 1);
               end else begin
                  src_valid = 1'b0;
               end
            end
         end
         begin
            repeat (120) begin
               @(negedge clk);
               if (req_o && !req_prev) begin
                  pulses++;
                  held = data_o;
                  if (data_o !== pulses) mon_bad++;
               end else if (req_o && data_o !== held) begin
                  mon_bad++;
               end
               req_prev = req_o;
            end
         end
      join
      chk("b2b pulse count", pulses, 3);
      chk("b2b data order/stability", mon_bad, 0);

      // Hold under a 50-cycle ack stall while src_data toggles.
      @(negedge clk);
      src_valid = 1'b1; src_data = 32'hA5A5_0001;
      @(negedge clk);
      bad_req = 0; bad_rdy = 0; bad_dat = 0;
      repeat (50) begin
         src_data = $urandom;
         #1;
         if (req_o !== 1'b1) bad_req++;
         if (src_ready !== 1'b0) bad_rdy++;
         if (data_o !== 32'hA5A5_0001) bad_dat++;
         @(negedge clk);
      end
      src_valid = 1'b0;
      chk("stall req_o held", bad_req, 0);
      chk("stall src_ready low", bad_rdy, 0);
      chk("stall data_o held", bad_dat, 0);
      remote_xfer(0, 32'hA5A5_0001, fall_d, rdy_d, bad);
      chk_rng("stall release fall delay", fall_d, 1, 3);
      chk_rng("stall release ready delay", rdy_d, 1, 3);

      // Asynchronous reset while in REQ.
      @(negedge clk);
      src_valid = 1'b1; src_data = 32'h1234_5678;
      @(negedge clk);
      src_valid = 1'b0;
      #1;
      chk("midrst data before", data_o, 32'h1234_5678);
      chk("midrst busy before", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst req_o", req_o, 0);
      chk("midrst data_o", data_o, 0);
      chk("midrst busy", busy, 0);
      chk("midrst proto_err", proto_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst src_ready after release", src_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sii_cdc_hs_tx.md
# sii_cdc_hs_tx

Source-domain end of a 4-phase req/ack handshake that carries a DATA_WIDTH-bit word into another clock domain. It accepts a word with a valid/ready handshake and holds it stable on `data_o`. It then drives `req_o` and tracks the remote `ack_i` through an internal flop-chain synchronizer. The destination side samples `data_o` with its own synchronized copy of `req_o`. This block sits in the `clk` domain next to the producer, for example a CSR or debug write path crossing to a slow peripheral clock.

## Interface
- DATA_WIDTH, 32, width of transferred word.
- SYNC_STAGES, 2, flop stages on `ack_i`; legal values are 2 or more.
- clk  input  1  source-domain clock.
- rst_n  input  1  reset, asynchronous, active-low.
- src_valid  input  1  producer has a word.
- src_data  input  DATA_WIDTH  word to send.
- src_ready  output  1  block can accept a word this cycle.
- req_o  output  1  handshake request to the remote domain, registered.
- data_o  output  DATA_WIDTH  held word to the remote domain, registered.
- ack_i  input  1  remote acknowledge, asynchronous to `clk`.
- busy  output  1  transfer in progress, meaning state is not IDLE.
- proto_err  output  1  sticky flag: `ack_i` seen high while IDLE.

## Operation
- **Synchronizer.** `ack_i` passes through SYNC_STAGES flops. All flops reset to 0. `ack_s` is the last stage. Nothing else reads `ack_i` directly.
- **IDLE.**
  - `src_ready` = 1 only when `ack_s` = 0.
  - When `src_valid` && `src_ready`: latch `src_data` into `data_o`, set `req_o` = 1, go to REQ.
- **REQ.**
  - `src_ready` = 0. `req_o` stays 1.
  - When `ack_s` = 1: clear `req_o`, go to REL.
- **REL.**
  - `src_ready` = 0. `req_o` = 0.
  - When `ack_s` = 0: go to IDLE.
- **`data_o` stability.** `data_o` changes only on an accept edge. It stays stable through REQ, REL and the following IDLE until the next accept.
- **`proto_err`.** Set when state is IDLE and `ack_s` = 1. It stays set until reset. The FSM still waits in IDLE with `src_ready` = 0 until `ack_s` returns to 0.
- **`src_data` outside accept.** `src_data` is ignored when `src_valid` is low or `src_ready` is 0.
- **`busy`** = (state != IDLE). It is a combinational decode of the state register.
- **Reset mid-transfer.** State goes to IDLE; `req_o`, `data_o`, sync flops and `proto_err` all go to 0. The remote domain must be reset together with this block; no recovery of a half-finished handshake is attempted.
- **Reset values.** `req_o` = 0, `data_o` = 0, `busy` = 0, `proto_err` = 0. `src_ready` = 1, since it decodes IDLE with `ack_s` = 0.

## Timing
- **Request rise.** Accept is sampled at edge N. `req_o` and `data_o` update at edge N, so `req_o` = 1 from N+1.
- **Acknowledge sync.** `ack_i` rises and is first sampled at edge M. `ack_s` = 1 after edge M+SYNC_STAGES-1. `req_o` falls after edge M+SYNC_STAGES.
- **Return to IDLE.** `ack_i` falls and is first sampled at edge K. `ack_s` = 0 after edge K+SYNC_STAGES-1, and the state is IDLE after edge K+SYNC_STAGES.
  - `src_ready` = 1 in that same cycle, combinational from state and `ack_s`.
- **Throughput.** The minimum cycle time is set by the remote round trip. There is no pipelining: at most one word is in flight.
- **Back-to-back.** If `src_valid` is held high, the next accept happens in the first IDLE cycle.
- **Sync-edge coincidence.** An `ack_i` edge landing exactly on a sync edge may resolve one cycle later. Benches must allow ±1 cycle on all ack-derived timing.

## Test plan
- **Reset.** Assert `rst_n` = 0, then release. Required response: `req_o` = 0, `data_o` = 0, `busy` = 0, `proto_err` = 0, `src_ready` = 1.
- **Single transfer.** Stimulus: `src_data` = 32'hDEAD_BEEF with `src_valid` for 1 cycle, and a remote model that raises `ack_i` 3 cycles after seeing `req_o`. Required response:
  - `req_o` rises 1 cycle after accept.
  - `req_o` falls 2 cycles (±1) after `ack_i` rises.
  - `data_o` = 32'hDEAD_BEEF throughout.
  - `src_ready` returns to 1 2 cycles (±1) after `ack_i` falls.
- **Back-to-back.** Stimulus: `src_valid` held high with values 1, 2, 3. Required response: exactly 3 req pulses. `data_o` takes 1, 2, 3 in order and stays stable on every `req_o` high interval.
- **Hold under stall.** Stimulus: `ack_i` withheld for 50 cycles while `src_data` toggles. Required response: `req_o` stays 1, `src_ready` = 0 and `data_o` is unchanged for the full 50 cycles.
- **Protocol error.** Stimulus: pulse `ack_i` high for 4 cycles while IDLE. Required response:
  - `proto_err` = 1 and remains 1 afterwards.
  - `src_ready` = 0 until `ack_s` clears.
  - A normal transfer then succeeds.
- **Reset mid-transfer.** Stimulus: assert `rst_n` low in REQ with `data_o` = 32'h1234_5678. Required response: `req_o` = 0, `data_o` = 0 and `busy` = 0 immediately (asynchronous); after release, `src_ready` = 1.
